// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared constants and FSM state type for the pipeline stage regs
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_reg_sat_counter.sv
// ============================================================================
// sat_counter : W-bit up-counter that sticks at all-ones; cleared only by rst
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// pipe_skid_reg : ready/valid pipeline register with 2-entry skid, flush and
//                 saturating stall counter. Rev 1.0
// ============================================================================
`default_nettype none

module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = XLEN,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             r_in_ready;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_stall;

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = out_valid & out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_state_nxt = ST_BUSY;
               w_main_nxt  = in_data;
            end
         end
         ST_BUSY: begin
            if (w_in_fire && w_out_fire) begin
               w_main_nxt = in_data;
            end else if (w_in_fire) begin
               w_state_nxt = ST_FULL;
               w_skid_nxt  = in_data;
            end else if (w_out_fire) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // Skid entry moves up behind the departing main entry to keep FIFO order.
            if (w_out_fire) begin
               w_state_nxt = ST_BUSY;
               w_main_nxt  = r_skid;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase

      // Flush drops held entries and any same-cycle capture; payload regs are left alone.
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = r_main;
         w_skid_nxt  = r_skid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_main     <= RESET_VAL;
         r_skid     <= RESET_VAL;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_main     <= w_main_nxt;
         r_skid     <= w_skid_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != ST_EMPTY);
   assign out_data  = r_main;
   assign w_stall   = out_valid & ~out_ready;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_stall),
      .count (stall_cnt)
   );

endmodule

`default_nettype wire
